instmem_fetch: RTL and testbench

INSTMEM_FETCH -- requirements
Module: instmem_fetch

---
 rtl/instmem_fetch.sv | 128 ++++++++++++
 tb/tb_instmem_fetch.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instmem_fetch.sv
// Instruction fetch unit: issues reads to a synchronous instruction memory and
// buffers returned words with their addresses in a small prefetch queue.
module instmem_fetch #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pc_load,
    input  logic [AW-1:0] pc_value,
    input  logic          fetch_en,
    output logic [AW-1:0] mem_adb,
    output logic          mem_ceb,
    output logic          mem_oce,
    input  logic [15:0]   mem_dout,
    output logic          ins_valid,
    input  logic          ins_ready,
    output logic [15:0]   ins_data,
    output logic [AW-1:0] ins_addr
);

    localparam int unsigned DW = 16;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] fetch_addr_q, fetch_addr_d;
    logic          inflight_q, inflight_d;
    logic [AW-1:0] infl_addr_q, infl_addr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [DW-1:0] q_data_q [DEPTH];
    logic [AW-1:0] q_addr_q [DEPTH];

    logic          issue_c;
    logic          push_c;
    logic          pop_c;
    logic          credit_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_STOP;
            fetch_addr_q <= '0;
            inflight_q   <= 1'b0;
            infl_addr_q  <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            inflight_q   <= inflight_d;
            infl_addr_q  <= infl_addr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    // Credit counts the in-flight read so a returning word always has a slot
    assign credit_c = (count_q + CW'(inflight_q)) < CW'(DEPTH);

    // Next-state: redirect wins over issue, push and pop
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        inflight_d   = 1'b0;
        infl_addr_d  = infl_addr_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        issue_c      = 1'b0;
        push_c       = 1'b0;
        pop_c        = 1'b0;

        if (pc_load) begin
            state_d      = ST_RUN;
            fetch_addr_d = pc_value;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
        end else begin
            issue_c = (state_q == ST_RUN) && fetch_en && credit_c;
            push_c  = inflight_q;
            pop_c   = ins_valid && ins_ready;

            if (issue_c) begin
                inflight_d   = 1'b1;
                infl_addr_d  = fetch_addr_q;
                fetch_addr_d = fetch_addr_q + AW'(1);
            end
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push_c) - CW'(pop_c);
        end
    end

    // Queue storage; the memory word is captured together with its issue address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_data_q <= '{default: '0};
            q_addr_q <= '{default: '0};
        end else if (push_c) begin
            q_data_q[wr_ptr_q] <= mem_dout;
            q_addr_q[wr_ptr_q] <= infl_addr_q;
        end
    end

    assign mem_adb   = fetch_addr_q;
    assign mem_ceb   = issue_c;
    assign mem_oce   = 1'b1;
    assign ins_valid = (count_q != '0);
    assign ins_data  = q_data_q[rd_ptr_q];
    assign ins_addr  = q_addr_q[rd_ptr_q];

endmodule

// File: tb/tb_instmem_fetch.sv
// Scoreboard bench for instmem_fetch: stimulus queues expected words,
// a negedge monitor pops and compares on every consumer handshake.
module tb_instmem_fetch;

    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pc_load = 1'b0;
    logic [AW-1:0] pc_value = '0;
    logic          fetch_en = 1'b0;
    logic [AW-1:0] mem_adb;
    logic          mem_ceb;
    logic          mem_oce;
    logic [15:0]   mem_dout = '0;
    logic          ins_valid;
    logic          ins_ready = 1'b0;
    logic [15:0]   ins_data;
    logic [AW-1:0] ins_addr;

    instmem_fetch #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc_load   (pc_load),
        .pc_value  (pc_value),
        .fetch_en  (fetch_en),
        .mem_adb   (mem_adb),
        .mem_ceb   (mem_ceb),
        .mem_oce   (mem_oce),
        .mem_dout  (mem_dout),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .ins_data  (ins_data),
        .ins_addr  (ins_addr)
    );

    always #5 clk = ~clk;

    // Synchronous memory: word k holds k + 0x1000
    always @(posedge clk) begin
        if (mem_ceb) mem_dout <= 16'h1000 + 16'(mem_adb);
    end

    typedef struct packed {
        logic [AW-1:0] a;
        logic [15:0]   d;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            failures = 0;
    int            hs_cnt = 0;
    int            ceb_cnt = 0;
    logic          hold_prev = 1'b0;
    logic [AW-1:0] hold_a = '0;
    logic [15:0]   hold_d = '0;

    always @(posedge clk) begin
        if (mem_ceb) ceb_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: compare each handshake against the scoreboard, and check hold stability
    always @(negedge clk) begin
        if (rst_n && !pc_load && ins_valid && ins_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_word: got addr 0x%0h data 0x%0h expected none", ins_addr, ins_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_addr", 32'(ins_addr), 32'(mon_e.a));
                chk("sb_data", 32'(ins_data), 32'(mon_e.d));
            end
        end
        if (hold_prev && rst_n) begin
            chk("hold_addr", 32'(ins_addr), 32'(hold_a));
            chk("hold_data", 32'(ins_data), 32'(hold_d));
        end
        hold_prev = rst_n && !pc_load && ins_valid && !ins_ready;
        hold_a    = ins_addr;
        hold_d    = ins_data;
    end

    // Drives pc_load for one edge and loads the scoreboard with the new stream
    task automatic redirect(input logic [AW-1:0] a, input int n);
        logic [AW-1:0] ai;
        exp_t          e;
        pc_load  = 1'b1;
        pc_value = a;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            ai  = a + AW'(i);
            e.a = ai;
            e.d = 16'h1000 + 16'(ai);
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        pc_load = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        int h0;

        // Reset values
        fetch_en  = 1'b1;
        ins_ready = 1'b1;
        @(negedge clk);
        chk("rst_valid", 32'(ins_valid), 0);
        chk("rst_data",  32'(ins_data),  0);
        chk("rst_addr",  32'(ins_addr),  0);
        chk("rst_ceb",   32'(mem_ceb),   0);
        chk("rst_adb",   32'(mem_adb),   0);
        chk("rst_oce",   32'(mem_oce),   1);

        // Release reset: no fetch until pc_load
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        c0 = ceb_cnt;
        step(5);
        chk("idle_ceb_pulses", 32'(ceb_cnt - c0), 0);
        chk("idle_valid", 32'(ins_valid), 0);

        // Basic stream from 0x010 with latency check
        redirect(10'h010, 64);
        @(negedge clk);
        chk("a_ceb_first", 32'(mem_ceb), 1);
        chk("a_adb_first", 32'(mem_adb), 32'h010);
        chk("a_valid_c1",  32'(ins_valid), 0);
        @(negedge clk);
        chk("a_valid_c2",  32'(ins_valid), 0);
        chk("a_adb_next",  32'(mem_adb), 32'h011);
        @(negedge clk);
        chk("a_valid_c3",  32'(ins_valid), 1);
        chk("a_addr0",     32'(ins_addr), 32'h010);
        chk("a_data0",     32'(ins_data), 32'h1010);
        step(1);
        h0 = hs_cnt;
        step(10);
        chk("a_rate", 32'(hs_cnt - h0), 10);

        // Address wrap 0x3FE -> 0x001
        redirect(10'h3FE, 64);
        h0 = hs_cnt;
        step(8);
        chk("b_wrap_count", 32'(hs_cnt - h0), 6);

        // Consumer stalled from the start: exactly DEPTH reads, then drain
        ins_ready = 1'b0;
        redirect(10'h040, 64);
        c0 = ceb_cnt;
        step(12);
        chk("c_reads_full", 32'(ceb_cnt - c0), DEPTH);
        chk("c_ceb_stall",  32'(mem_ceb), 0);
        chk("c_valid",      32'(ins_valid), 1);
        chk("c_head_addr",  32'(ins_addr), 32'h040);
        chk("c_head_data",  32'(ins_data), 32'h1040);
        ins_ready = 1'b1;
        h0 = hs_cnt;
        step(12);
        chk("c_drain_rate", 32'(hs_cnt - h0), 12);

        // Redirect while 3 words queued and a read in flight
        ins_ready = 1'b0;
        redirect(10'h080, 64);
        step(4);
        @(negedge clk);
        chk("d_valid_pre", 32'(ins_valid), 1);
        chk("d_addr_pre",  32'(ins_addr), 32'h080);
        ins_ready = 1'b1;
        redirect(10'h200, 64);
        @(negedge clk);
        chk("d_flush_c1", 32'(ins_valid), 0);
        @(negedge clk);
        chk("d_flush_c2", 32'(ins_valid), 0);
        @(negedge clk);
        chk("d_first_valid", 32'(ins_valid), 1);
        chk("d_first_addr",  32'(ins_addr), 32'h200);
        chk("d_first_data",  32'(ins_data), 32'h1200);
        step(4);

        // fetch_en dropped for 5 cycles mid-stream
        redirect(10'h100, 64);
        step(6);
        fetch_en = 1'b0;
        c0 = ceb_cnt;
        h0 = hs_cnt;
        step(5);
        chk("e_ceb_window", 32'(ceb_cnt - c0), 0);
        chk("e_inflight_hs", 32'(hs_cnt - h0), 2);
        fetch_en = 1'b1;
        h0 = hs_cnt;
        step(10);
        chk("e_resume_hs", 32'(hs_cnt - h0), 8);

        // Reset pulse mid-stream
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("f_valid_rst", 32'(ins_valid), 0);
        chk("f_data_rst",  32'(ins_data), 0);
        chk("f_ceb_rst",   32'(mem_ceb), 0);
        chk("f_adb_rst",   32'(mem_adb), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        c0 = ceb_cnt;
        step(6);
        chk("f_no_reads", 32'(ceb_cnt - c0), 0);
        chk("f_valid_idle", 32'(ins_valid), 0);
        redirect(10'h2A0, 16);
        h0 = hs_cnt;
        step(6);
        chk("f_restart_hs", 32'(hs_cnt - h0), 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
